// File: rtl/xbtn_capture_pkg.sv
// Common types and helpers for the button capture block.
// Optional auto-repeat is enabled by defining BTN_REPEAT_EN.
`include "xdefs.vh"

package xbtn_capture_pkg;

    localparam int BTN_N = `BTN_N;

    typedef logic [BTN_N-1:0] btn_vec_t;

    // Set wins over clear so a press landing on a clear strobe is never lost.
    function automatic btn_vec_t next_event(input btn_vec_t ev, input btn_vec_t clr, input btn_vec_t set);
        return (ev & ~clr) | set;
    endfunction

    function automatic logic any_set(input btn_vec_t v);
        return |v;
    endfunction

endpackage

// File: rtl/xbtn_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter, level register and
// press detect; auto-repeat timer only when BTN_REPEAT_EN is defined.
`include "xdefs.vh"

module xbtn_debounce
    import xbtn_capture_pkg::*;
#(
    parameter int DB_CYCLES = `XBTN_DB_CYCLES,
    parameter int CNT_W     = `XBTN_CNT_W
`ifdef BTN_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic sync1_r;
    logic sync2_r;
    logic level_r;
    logic [CNT_W-1:0] cnt_r;
    logic rise_s;

    // Two-stage synchronizer for the asynchronous board input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    // Asserted in the cycle before the edge on which the level goes 0->1.
    assign rise_s = sync2_r && !level_r && (cnt_r == CNT_LAST);
    assign level  = level_r;

`ifdef BTN_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_r;
    logic rep_hit_s;

    // Repeat timer runs from the press edge while the level stays high.
    always_ff @(posedge clk) begin
        if (rst || !level_r) begin
            rep_cnt_r <= {REP_W{1'b0}};
        end else if (rep_cnt_r == REP_LAST) begin
            rep_cnt_r <= {REP_W{1'b0}};
        end else begin
            rep_cnt_r <= rep_cnt_r + REP_W'(1);
        end
    end

    assign rep_hit_s = level_r && (rep_cnt_r == REP_LAST);
    assign press     = rise_s | rep_hit_s;
`else
    assign press     = rise_s;
`endif

endmodule

// File: rtl/xdefs.vh
// Shared build defines for the button capture block: channel count and the
// default debounce timing used when no parameter override is given.
`ifndef XDEFS_VH
`define XDEFS_VH
`define BTN_N          4
`define XBTN_DB_CYCLES 1000000
`define XBTN_CNT_W     20
`endif

// File: rtl/xbtn_capture.sv
// Four-button capture: per-channel debounce plus sticky, write-one-to-clear
// press-event flags. Define BTN_REPEAT_EN to enable held-button auto-repeat.
`include "xdefs.vh"

module xbtn_capture
    import xbtn_capture_pkg::*;
#(
    parameter int DB_CYCLES     = `XBTN_DB_CYCLES,
    parameter int CNT_W         = `XBTN_CNT_W,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_N-1:0] btn_raw,
    input  logic [BTN_N-1:0] ev_clr,
    output logic [BTN_N-1:0] btn_level,
    output logic [BTN_N-1:0] btn_event,
    output logic             btn_any
);

    btn_vec_t press_s;
    btn_vec_t event_r;

    for (genvar i = 0; i < BTN_N; i++) begin : g_ch
        xbtn_debounce #(
            .DB_CYCLES     (DB_CYCLES),
            .CNT_W         (CNT_W)
`ifdef BTN_REPEAT_EN
            ,
            .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (press_s[i])
        );
    end

    // Sticky event flags, cleared by the decoder's write-one strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            event_r <= {BTN_N{1'b0}};
        end else begin
            event_r <= next_event(event_r, ev_clr, press_s);
        end
    end

    assign btn_event = event_r;
    assign btn_any   = any_set(event_r);

endmodule

// File: tb/tb_xbtn_capture.sv
// Bench for xbtn_capture with DB_CYCLES=4, REPEAT_CYCLES=20: directed table,
// auto-repeat sequence and randomized traffic against a behavioural model.
module tb_xbtn_capture;

    localparam int DB  = 4;
    localparam int REP = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'h0;
    logic [3:0] ev_clr = 4'h0;
    logic [3:0] btn_level;
    logic [3:0] btn_event;
    logic       btn_any;

    xbtn_capture #(.DB_CYCLES(DB), .CNT_W(4), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .ev_clr(ev_clr),
        .btn_level(btn_level), .btn_event(btn_event), .btn_any(btn_any)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model state: synchronizer stages, accepted level, sticky flags, and per
    // channel the disagreement streak and cycles elapsed since the press edge.
    logic [3:0] m_s1 = 4'h0, m_s2 = 4'h0, m_lvl = 4'h0, m_ev = 4'h0;
    int m_streak[4];
    int m_age[4];

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [3:0] fire;
        fire = 4'h0;
        if (rst) begin
            m_s1 = 4'h0; m_s2 = 4'h0; m_lvl = 4'h0; m_ev = 4'h0;
            for (int i = 0; i < 4; i++) begin
                m_streak[i] = 0;
                m_age[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_lvl[i]) begin
                    m_age[i]++;
`ifdef BTN_REPEAT_EN
                    if (m_age[i] % REP == 0) fire[i] = 1'b1;
`endif
                end
                if (m_s2[i] != m_lvl[i]) begin
                    m_streak[i]++;
                    if (m_streak[i] == DB) begin
                        m_lvl[i] = m_s2[i];
                        m_streak[i] = 0;
                        if (m_lvl[i]) begin
                            fire[i] = 1'b1;
                            m_age[i] = 0;
                        end
                    end
                end else begin
                    m_streak[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
            m_ev = (m_ev & ~ev_clr) | fire;
        end
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check("model_level", btn_level, m_lvl);
        check("model_event", btn_event, m_ev);
        check("model_any", {3'b000, btn_any}, {3'b000, |m_ev});
    endtask

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] raw;
        logic [3:0] clr;
        int         n;
        logic [3:0] lvl;
        logic [3:0] ev;
        logic       any;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string nm, input logic r, input logic [3:0] raw,
                                input logic [3:0] clr, input int n, input logic [3:0] lvl,
                                input logic [3:0] ev, input logic any);
        vec_t v;
        v.name = nm; v.rst = r; v.raw = raw; v.clr = clr; v.n = n;
        v.lvl = lvl; v.ev = ev; v.any = any;
        tbl.push_back(v);
    endfunction

    initial begin
        int exp_off[$];
        int got_off[$];
        int p;
        logic seen;

        add("reset",          1'b1, 4'h0, 4'h0, 3, 4'h0, 4'h0, 1'b0);
        add("pre_latency",    1'b0, 4'hF, 4'h0, 5, 4'h0, 4'h0, 1'b0);
        add("latency6",       1'b0, 4'hF, 4'h0, 1, 4'hF, 4'hF, 1'b1);
        add("clear_all",      1'b0, 4'hF, 4'hF, 1, 4'hF, 4'h0, 1'b0);
        add("release_hold",   1'b0, 4'h0, 4'h0, 5, 4'hF, 4'h0, 1'b0);
        add("release_done",   1'b0, 4'h0, 4'h0, 1, 4'h0, 4'h0, 1'b0);
        add("glitch",         1'b0, 4'h2, 4'h0, 3, 4'h0, 4'h0, 1'b0);
        add("glitch_after",   1'b0, 4'h0, 4'h0, 8, 4'h0, 4'h0, 1'b0);
        add("press2",         1'b0, 4'h4, 4'h0, 6, 4'h4, 4'h4, 1'b1);
        add("clear2",         1'b0, 4'h4, 4'h4, 1, 4'h4, 4'h0, 1'b0);
        add("release2",       1'b0, 4'h0, 4'h0, 6, 4'h0, 4'h0, 1'b0);
        add("pre_rise0",      1'b0, 4'h1, 4'h0, 5, 4'h0, 4'h0, 1'b0);
        add("set_beats_clr",  1'b0, 4'h1, 4'h1, 1, 4'h1, 4'h1, 1'b1);
        add("clear0",         1'b0, 4'h1, 4'h1, 1, 4'h1, 4'h0, 1'b0);
        add("release0",       1'b0, 4'h0, 4'h0, 6, 4'h0, 4'h0, 1'b0);
        add("midcount",       1'b0, 4'h8, 4'h0, 4, 4'h0, 4'h0, 1'b0);
        add("rst_midcount",   1'b1, 4'h8, 4'h0, 1, 4'h0, 4'h0, 1'b0);
        add("post_rst_wait",  1'b0, 4'h8, 4'h0, 5, 4'h0, 4'h0, 1'b0);
        add("post_rst_rise",  1'b0, 4'h8, 4'h0, 1, 4'h8, 4'h8, 1'b1);
        add("release3",       1'b0, 4'h0, 4'h8, 6, 4'h0, 4'h0, 1'b0);

        @(negedge clk);
        foreach (tbl[k]) begin
            rst = tbl[k].rst; btn_raw = tbl[k].raw; ev_clr = tbl[k].clr;
            for (int c = 0; c < tbl[k].n; c++) step();
            check({tbl[k].name, "_level"}, btn_level, tbl[k].lvl);
            check({tbl[k].name, "_event"}, btn_event, tbl[k].ev);
            check({tbl[k].name, "_any"}, {3'b000, btn_any}, {3'b000, tbl[k].any});
        end
        rst = 1'b0; ev_clr = 4'h0;

        // Held button 0, clearing each time the flag is seen set.
        btn_raw = 4'h1;
        seen = 1'b0;
        for (int t = 0; t < 12 && !seen; t++) begin
            step();
            if (btn_level[0]) seen = 1'b1;
        end
        check("repeat_press_seen", {3'b000, seen}, 4'h1);
        p = cyc;
        for (int k = 0; k < 70; k++) begin
            ev_clr = {3'b000, btn_event[0]};
            step();
            if (btn_event[0]) got_off.push_back(cyc - p);
        end
`ifdef BTN_REPEAT_EN
        exp_off = '{20, 40, 60};
`endif
        check("repeat_count", 4'(got_off.size()), 4'(exp_off.size()));
        for (int k = 0; k < exp_off.size() && k < got_off.size(); k++)
            check("repeat_offset", 4'(got_off[k] / 4), 4'(exp_off[k] / 4));
        btn_raw = 4'h0; ev_clr = 4'hF;
        for (int c = 0; c < 8; c++) step();

        // Randomized traffic: sparse toggles give both long holds and glitches.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) btn_raw[b] = ~btn_raw[b];
            ev_clr = 4'($urandom) & 4'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbtn_capture.md
XBTN_CAPTURE -- requirements
Module: xbtn_capture

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept a new button level (10 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, meaning debounce counter width; DB_CYCLES SHALL fit within CNT_W bits.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 25000000, meaning auto-repeat period in cycles (used only with BTN_REPEAT_EN).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port btn_raw  input  4  asynchronous raw board buttons.
REQ-007 SHALL have port ev_clr  input  4  write-one-to-clear strobe for the event bits, driven by the address decoder on a button-register write.
REQ-008 SHALL have port btn_level  output  4  debounced button levels, 1 = pressed.
REQ-009 SHALL have port btn_event  output  4  sticky press-event flags, which feed the decoder button_in.
REQ-010 SHALL have port btn_any  output  1  OR of btn_event.

Function
REQ-011 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep one counter per button: the counter increments while the synchronized bit differs from btn_level and clears to 0 on any cycle where they match.
REQ-013 SHALL update btn_level[i] to the synchronized value, and clear counter i, on the edge where counter i would reach DB_CYCLES; raw-to-level latency SHALL be DB_CYCLES+2 cycles.
REQ-014 SHALL discard any glitch shorter than DB_CYCLES synchronized cycles, leaving level and event unchanged.
REQ-015 SHALL set btn_event[i] on the same edge that btn_level[i] goes 0->1; a 1->0 level transition SHALL NOT touch events.
REQ-016 SHALL keep btn_event[i] set until a cycle with ev_clr[i]=1; the bit SHALL clear on the following edge.
REQ-017 SHALL give priority to set when a set and ev_clr[i] occur in the same cycle, so the bit stays 1 and no press is lost.
REQ-018 SHALL leave a set event bit at 1 when a second press arrives, with no counting and no overflow indication.
REQ-019 SHALL treat the four channels fully independently; simultaneous presses on several buttons SHALL each set their own bit in the same cycle.
REQ-020 SHALL derive btn_any combinationally from the btn_event registers.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, clear synchronizer flops, counters, btn_level, btn_event and btn_any to 0.
REQ-022 SHALL discard an in-progress debounce when reset arrives mid-count; after release, a still-held button SHALL need a full DB_CYCLES+2 again and then SHALL produce one event.

Configuration
REQ-023 SHALL support macro BTN_REPEAT_EN; when defined, a button whose level stays 1 SHALL re-set its event bit every REPEAT_CYCLES cycles, counted from the press edge, with the repeat counter cleared when the level falls or on reset.
REQ-024 SHALL, without BTN_REPEAT_EN, set events only on 0->1 level transitions and SHALL synthesize no repeat counters.

Structure
REQ-025 SHALL take the button count (BTN_N=4) and the default DB_CYCLES/CNT_W values as defines in the shared xdefs.vh.
REQ-026 SHALL implement one channel (synchronizer, counter, level, edge detect, optional repeat) as sub-module xbtn_debounce, instantiated BTN_N times; the event registers and the clear logic SHALL live in xbtn_capture.

Verification (bench uses DB_CYCLES=4, REPEAT_CYCLES=20)
REQ-027 SHALL cover: rst=1 for 3 cycles, then btn_raw=4'hF -> outputs 0 during reset; btn_level=4'hF and btn_event=4'hF exactly 6 cycles after the raw change.
REQ-028 SHALL cover: btn_raw[1] pulsed high for 3 cycles -> btn_level and btn_event stay 4'h0.
REQ-029 SHALL cover: btn_raw[2] held high -> btn_event=4'h4 and btn_any=1; then ev_clr=4'h4 for one cycle -> btn_event=4'h0 on the next edge, with btn_level[2] still 1.
REQ-030 SHALL cover: ev_clr[0]=1 asserted on the exact edge where btn_level[0] rises -> btn_event[0]=1 afterwards.
REQ-031 SHALL cover: btn_raw[3] held, rst pulsed 1 cycle at counter=2 -> level stays 0, then rises 6 cycles after reset release.
REQ-032 SHALL cover, with BTN_REPEAT_EN: btn_raw[0] held 70 cycles, clearing after each set -> event re-sets at 20, 40 and 60 cycles after the press edge; without the macro -> one event only.
